// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forward-select codes,
// memory-wait FSM states and a saturating counter helper.
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
    return (en && value != 32'hFFFF_FFFF) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Multi-cycle data-memory wait sequencer: stalls the pipeline for exactly
// MEM_WAIT cycles per access, then spends one DONE cycle so it cannot retrigger.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic acc,
  output logic mem_stall,
  output logic mem_busy
);

  localparam logic [CNT_W-1:0] CNT_INIT = (MEM_WAIT >= 2) ? CNT_W'(MEM_WAIT - 2) : '0;

  mem_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             stall;

  // NOTE: state registers take non-blocking assignments so every flop samples
  // the pre-edge values; the combinational block below uses blocking ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (acc && MEM_WAIT >= 2) begin
          stall    = 1'b1;
          state_nx = WAIT;
          cnt_nx   = CNT_INIT;
        end else if (acc && MEM_WAIT == 1) begin
          stall    = 1'b1;
          state_nx = DONE;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == '0) state_nx = DONE;
        else           cnt_nx   = cnt - 1'b1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign mem_stall = stall & ~rst_i;
  assign mem_busy  = mem_stall;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Combined forwarding / load-use / branch-interlock / memory-wait controller.
// Optional HAZARD_PERF_EN adds saturating stall and flush event counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [REG_AW-1:0]         id_rs_i,
  input  logic [REG_AW-1:0]         id_rt_i,
  input  logic                      id_uses_rt_i,
  input  logic                      id_branch_i,
  input  logic                      id_taken_i,
  input  logic                      id_jump_i,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src_i,
  input  logic [REG_AW-1:0]         ex_rd_i,
  input  logic                      ex_regwrite_i,
  input  logic                      ex_memread_i,
  input  logic [REG_AW-1:0]         mem_rd_i,
  input  logic                      mem_regwrite_i,
  input  logic                      mem_memread_i,
  input  logic                      mem_memwrite_i,
  input  logic [REG_AW-1:0]         wb_rd_i,
  input  logic                      wb_regwrite_i,
  output logic [NUM_SRC*2-1:0]      fwd_sel_o,
  output logic                      pc_hold_o,
  output logic                      ifid_hold_o,
  output logic                      ifid_flush_o,
  output logic                      idex_bubble_o,
  output logic                      idex_hold_o,
  output logic                      exmem_hold_o,
  output logic                      memwb_bubble_o,
`ifdef HAZARD_PERF_EN
  output logic [31:0]               perf_lu_o,
  output logic [31:0]               perf_mem_o,
  output logic [31:0]               perf_flush_o,
`endif
  output logic                      mem_busy_o
);

  logic run;
  logic mem_stall, mem_busy;
  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic lu, br, id_stall, flush;

  assign run = ~rst_i;

  mem_wait_fsm #(.MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)) u_mem_wait (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .acc       (mem_memread_i | mem_memwrite_i),
    .mem_stall (mem_stall),
    .mem_busy  (mem_busy)
  );

  always_comb begin
    fwd_sel_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mem_regwrite_i && mem_rd_i != '0 && mem_rd_i == ex_src_i[i*REG_AW +: REG_AW])
        fwd_sel_o[i*2 +: 2] = FWD_MEM;
      else if (wb_regwrite_i && wb_rd_i != '0 && wb_rd_i == ex_src_i[i*REG_AW +: REG_AW])
        fwd_sel_o[i*2 +: 2] = FWD_WB;
      else
        fwd_sel_o[i*2 +: 2] = FWD_REG;
    end
    if (!run) fwd_sel_o = '0;
  end

  assign ex_hit_rs  = (ex_rd_i  != '0) && (ex_rd_i  == id_rs_i);
  assign ex_hit_rt  = (ex_rd_i  != '0) && (ex_rd_i  == id_rt_i);
  assign mem_hit_rs = (mem_rd_i != '0) && (mem_rd_i == id_rs_i);
  assign mem_hit_rt = (mem_rd_i != '0) && (mem_rd_i == id_rt_i);

  assign lu = ex_memread_i & (ex_hit_rs | (ex_hit_rt & id_uses_rt_i));
  // The ID-stage comparator needs both operands final: wait on an in-flight ALU
  // result in EX or a load still in MEM.
  assign br = id_branch_i & ((ex_regwrite_i & (ex_hit_rs | ex_hit_rt)) |
                             (mem_memread_i & (mem_hit_rs | mem_hit_rt)));

  assign id_stall = run & (lu | br);
  assign flush    = run & (id_jump_i | (id_branch_i & id_taken_i)) & ~id_stall & ~mem_stall;

  assign pc_hold_o      = id_stall | mem_stall;
  assign ifid_hold_o    = id_stall | mem_stall;
  assign ifid_flush_o   = flush;
  assign idex_bubble_o  = id_stall & ~mem_stall;
  assign idex_hold_o    = mem_stall;
  assign exmem_hold_o   = mem_stall;
  assign memwb_bubble_o = mem_stall;
  assign mem_busy_o     = mem_busy;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_q, perf_mem_q, perf_flush_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_lu_q    <= '0;
      perf_mem_q   <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_lu_q    <= sat_inc(perf_lu_q, id_stall & ~mem_stall);
      perf_mem_q   <= sat_inc(perf_mem_q, mem_stall);
      perf_flush_q <= sat_inc(perf_flush_q, flush);
    end
  end

  assign perf_lu_o    = run ? perf_lu_q    : '0;
  assign perf_mem_o   = run ? perf_mem_q   : '0;
  assign perf_flush_o = run ? perf_flush_q : '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with MEM_WAIT=0 and one
// with MEM_WAIT=3 share stimulus; HAZARD_PERF_EN adds counter checks.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;

  logic                      clk = 1'b0;
  logic                      rst_i;
  logic [REG_AW-1:0]         id_rs_i, id_rt_i, ex_rd_i, mem_rd_i, wb_rd_i;
  logic                      id_uses_rt_i, id_branch_i, id_taken_i, id_jump_i;
  logic [NUM_SRC*REG_AW-1:0] ex_src_i;
  logic                      ex_regwrite_i, ex_memread_i;
  logic                      mem_regwrite_i, mem_memread_i, mem_memwrite_i, wb_regwrite_i;

  logic [NUM_SRC*2-1:0] fwd0, fwd3;
  logic pc0, ih0, if0, ib0, xh0, eh0, mb0, bz0;
  logic pc3, ih3, if3, ib3, xh3, eh3, mb3, bz3;
  logic [7:0] ctl0, ctl3;
`ifdef HAZARD_PERF_EN
  logic [31:0] plu0, pmem0, pfl0, plu3, pmem3, pfl3;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MEM_WAIT(0), .CNT_W(4)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_uses_rt_i(id_uses_rt_i), .id_branch_i(id_branch_i), .id_taken_i(id_taken_i),
    .id_jump_i(id_jump_i), .ex_src_i(ex_src_i), .ex_rd_i(ex_rd_i),
    .ex_regwrite_i(ex_regwrite_i), .ex_memread_i(ex_memread_i), .mem_rd_i(mem_rd_i),
    .mem_regwrite_i(mem_regwrite_i), .mem_memread_i(mem_memread_i),
    .mem_memwrite_i(mem_memwrite_i), .wb_rd_i(wb_rd_i), .wb_regwrite_i(wb_regwrite_i),
    .fwd_sel_o(fwd0), .pc_hold_o(pc0), .ifid_hold_o(ih0), .ifid_flush_o(if0),
    .idex_bubble_o(ib0), .idex_hold_o(xh0), .exmem_hold_o(eh0), .memwb_bubble_o(mb0),
`ifdef HAZARD_PERF_EN
    .perf_lu_o(plu0), .perf_mem_o(pmem0), .perf_flush_o(pfl0),
`endif
    .mem_busy_o(bz0)
  );

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MEM_WAIT(3), .CNT_W(4)) dut3 (
    .clk_i(clk), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_uses_rt_i(id_uses_rt_i), .id_branch_i(id_branch_i), .id_taken_i(id_taken_i),
    .id_jump_i(id_jump_i), .ex_src_i(ex_src_i), .ex_rd_i(ex_rd_i),
    .ex_regwrite_i(ex_regwrite_i), .ex_memread_i(ex_memread_i), .mem_rd_i(mem_rd_i),
    .mem_regwrite_i(mem_regwrite_i), .mem_memread_i(mem_memread_i),
    .mem_memwrite_i(mem_memwrite_i), .wb_rd_i(wb_rd_i), .wb_regwrite_i(wb_regwrite_i),
    .fwd_sel_o(fwd3), .pc_hold_o(pc3), .ifid_hold_o(ih3), .ifid_flush_o(if3),
    .idex_bubble_o(ib3), .idex_hold_o(xh3), .exmem_hold_o(eh3), .memwb_bubble_o(mb3),
`ifdef HAZARD_PERF_EN
    .perf_lu_o(plu3), .perf_mem_o(pmem3), .perf_flush_o(pfl3),
`endif
    .mem_busy_o(bz3)
  );

  // {pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold, exmem_hold, memwb_bubble, mem_busy}
  assign ctl0 = {pc0, ih0, if0, ib0, xh0, eh0, mb0, bz0};
  assign ctl3 = {pc3, ih3, if3, ib3, xh3, eh3, mb3, bz3};

  localparam logic [7:0] C_NONE  = 8'h00;
  localparam logic [7:0] C_IDST  = 8'hD0;
  localparam logic [7:0] C_FLUSH = 8'h20;
  localparam logic [7:0] C_MEMST = 8'hCF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs_i = '0; id_rt_i = '0; id_uses_rt_i = 0; id_branch_i = 0; id_taken_i = 0;
    id_jump_i = 0; ex_src_i = '0; ex_rd_i = '0; ex_regwrite_i = 0; ex_memread_i = 0;
    mem_rd_i = '0; mem_regwrite_i = 0; mem_memread_i = 0; mem_memwrite_i = 0;
    wb_rd_i = '0; wb_regwrite_i = 0;
  endtask

  initial begin
    clear_inputs();
    rst_i = 1;
    tick(); tick();
    // Hazards present while reset is held: everything must stay low.
    mem_rd_i = 5'd3; mem_regwrite_i = 1; ex_src_i = {5'd0, 5'd3};
    ex_memread_i = 1; ex_rd_i = 5'd5; id_rs_i = 5'd5; mem_memread_i = 1;
    #1;
    chk("rst_fwd", 32'(fwd0), 32'h0);
    chk("rst_ctl0", 32'(ctl0), 32'(C_NONE));
    chk("rst_ctl3", 32'(ctl3), 32'(C_NONE));

    // Forwarding priority and register-0 exclusion
    tick(); rst_i = 0; clear_inputs();
    mem_rd_i = 5'd3; mem_regwrite_i = 1; wb_rd_i = 5'd3; wb_regwrite_i = 1;
    ex_src_i = {5'd4, 5'd3}; #1;
    chk("fwd_mem_prio", 32'(fwd0), 32'h2);
    tick(); mem_regwrite_i = 0; #1;
    chk("fwd_wb", 32'(fwd0), 32'h1);
    tick(); mem_regwrite_i = 1; ex_src_i = {5'd3, 5'd3}; wb_rd_i = 5'd4; #1;
    chk("fwd_both_mem", 32'(fwd0), 32'hA);
    tick(); ex_src_i = {5'd4, 5'd3}; #1;
    chk("fwd_mixed", 32'(fwd0), 32'h6);
    tick(); mem_rd_i = '0; wb_rd_i = '0; ex_src_i = {5'd0, 5'd0}; #1;
    chk("fwd_r0", 32'(fwd0), 32'h0);

    // Load-use stall
    tick(); clear_inputs(); ex_memread_i = 1; ex_rd_i = 5'd5; id_rs_i = 5'd5; #1;
    chk("lu_rs", 32'(ctl0), 32'(C_IDST));
    tick(); id_rs_i = 5'd1; id_rt_i = 5'd5; id_uses_rt_i = 0; #1;
    chk("lu_rt_unused", 32'(ctl0), 32'(C_NONE));
    tick(); id_uses_rt_i = 1; #1;
    chk("lu_rt_used", 32'(ctl0), 32'(C_IDST));
    tick(); ex_rd_i = '0; id_rs_i = '0; id_rt_i = '0; #1;
    chk("lu_r0", 32'(ctl0), 32'(C_NONE));

    // Branch interlock beats flush, then flush once the hazard clears
    tick(); clear_inputs();
    id_branch_i = 1; id_taken_i = 1; ex_rd_i = 5'd7; ex_regwrite_i = 1; id_rs_i = 5'd7; #1;
    chk("br_ex_stall", 32'(ctl0), 32'(C_IDST));
    tick(); ex_regwrite_i = 0; #1;
    chk("br_flush", 32'(ctl0), 32'(C_FLUSH));
    tick(); clear_inputs(); id_branch_i = 1; mem_rd_i = 5'd9; mem_memread_i = 1; id_rs_i = 5'd9; #1;
    chk("br_mem_load", 32'(ctl0), 32'(C_IDST));
    tick(); mem_memread_i = 0; mem_regwrite_i = 1; #1;
    chk("br_mem_alu", 32'(ctl0), 32'(C_NONE));
    tick(); clear_inputs(); id_jump_i = 1; #1;
    chk("jump_flush", 32'(ctl0), 32'(C_FLUSH));
    tick(); clear_inputs();
    tick(); tick(); tick(); tick();

    // MEM_WAIT=3: three stall cycles, a DONE cycle, then immediate retrigger
    mem_memread_i = 1; #1;
    chk("mw_c1", 32'(ctl3), 32'(C_MEMST));
    chk("mw0_never", 32'(ctl0), 32'(C_NONE));
    tick(); chk("mw_c2", 32'(ctl3), 32'(C_MEMST));
    tick(); chk("mw_c3", 32'(ctl3), 32'(C_MEMST));
    tick(); chk("mw_done", 32'(ctl3), 32'(C_NONE));
    tick(); chk("mw2_c1", 32'(ctl3), 32'(C_MEMST));
    tick(); chk("mw2_c2", 32'(ctl3), 32'(C_MEMST));
    tick(); chk("mw2_c3", 32'(ctl3), 32'(C_MEMST));
    tick(); mem_memread_i = 0; #1;
    chk("mw2_done", 32'(ctl3), 32'(C_NONE));
    tick(); chk("mw_idle", 32'(ctl3), 32'(C_NONE));

    // Load-use and jump raised during a write wait stay masked until it ends
    tick(); mem_memwrite_i = 1; ex_memread_i = 1; ex_rd_i = 5'd5; id_rs_i = 5'd5; id_jump_i = 1; #1;
    chk("mask_c1", 32'(ctl3), 32'(C_MEMST));
    tick(); chk("mask_c2", 32'(ctl3), 32'(C_MEMST));
    tick(); chk("mask_c3", 32'(ctl3), 32'(C_MEMST));
    tick(); mem_memwrite_i = 0; #1;
    chk("mask_lu_wins", 32'(ctl3), 32'(C_IDST));
    tick(); ex_memread_i = 0; #1;
    chk("mask_flush", 32'(ctl3), 32'(C_FLUSH));
    tick(); clear_inputs(); #1;
    chk("mask_clear", 32'(ctl3), 32'(C_NONE));

    // Reset during WAIT abandons the access
    tick(); mem_memread_i = 1; #1;
    chk("rw_c1", 32'(ctl3), 32'(C_MEMST));
    tick(); rst_i = 1; mem_memread_i = 0; #1;
    chk("rw_in_rst", 32'(ctl3), 32'(C_NONE));
    tick(); rst_i = 0; #1;
    chk("rw_after", 32'(ctl3), 32'(C_NONE));
`ifdef HAZARD_PERF_EN
    chk("perf_mem_clr", pmem3, 32'h0);
`endif
    tick(); mem_memread_i = 1; #1;
    chk("rw_fresh", 32'(ctl3), 32'(C_MEMST));
    tick(); #1;
    chk("rw_fresh_c2", 32'(ctl3), 32'(C_MEMST));
`ifdef HAZARD_PERF_EN
    chk("perf_mem_one", pmem3, 32'h1);
`endif
    tick(); clear_inputs();
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the 5-stage pipelined CPU. It replaces the separate forwarding unit and hazard detector with one block, and generalises them to NUM_SRC EX-stage source operands. It adds two behaviours the current units lack: branch-operand interlock for ID-stage branch compare, and a multi-cycle data-memory wait FSM that freezes the pipeline. It drives the hold/bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, plus the EX operand mux selects.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, number of EX-stage source operands needing forwarding
MEM_WAIT, 0, stall cycles per data-memory access (0 = single-cycle memory, never stalls)
CNT_W, 4, wait counter width; must satisfy 2^CNT_W > MEM_WAIT

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
id_rs_i  in  REG_AW  ID-stage rs
id_rt_i  in  REG_AW  ID-stage rt
id_uses_rt_i  in  1  rt is a true source in ID
id_branch_i  in  1  branch in ID
id_taken_i  in  1  ID compare result is equal/taken
id_jump_i  in  1  jump in ID
ex_src_i  in  NUM_SRC*REG_AW  EX source registers; operand i is at [i*REG_AW +: REG_AW]
ex_rd_i  in  REG_AW  EX destination register
ex_regwrite_i  in  1  EX RegWrite
ex_memread_i  in  1  EX MemRead
mem_rd_i  in  REG_AW  MEM destination register
mem_regwrite_i  in  1  MEM RegWrite
mem_memread_i  in  1  MEM MemRead
mem_memwrite_i  in  1  MEM MemWrite
wb_rd_i  in  REG_AW  WB destination register
wb_regwrite_i  in  1  WB RegWrite
fwd_sel_o  out  NUM_SRC*2  per-operand forward select
pc_hold_o  out  1  freeze PC
ifid_hold_o  out  1  freeze IF/ID
ifid_flush_o  out  1  zero IF/ID
idex_bubble_o  out  1  load zero control into ID/EX
idex_hold_o  out  1  freeze ID/EX
exmem_hold_o  out  1  freeze EX/MEM
memwb_bubble_o  out  1  load zero control into MEM/WB
mem_busy_o  out  1  memory wait in progress

Behaviour:
- Clock domain and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Forwarding (combinational), per operand i:
  - 2'b10 when mem_regwrite_i, mem_rd_i != 0 and mem_rd_i == src.
  - Otherwise 2'b01 when wb_regwrite_i, wb_rd_i != 0 and wb_rd_i == src.
  - Otherwise 2'b00.
  - MEM has priority over WB. Register 0 is never forwarded.
- Load-use stall (lu): ex_memread_i, ex_rd_i != 0, and ex_rd_i matches id_rs_i, or matches id_rt_i with id_uses_rt_i set.
- Branch interlock (br): id_branch_i, and a matching nonzero register from either:
  - ex_rd_i with ex_regwrite_i, or
  - mem_rd_i with mem_memread_i.
- id_stall = lu | br. It drives pc_hold_o = ifid_hold_o = idex_bubble_o = 1.
- ifid_flush_o = (id_jump_i | (id_branch_i & id_taken_i)) & ~id_stall & ~mem_stall.
- Memory wait FSM, states IDLE/WAIT/DONE. acc = mem_memread_i | mem_memwrite_i.
  - IDLE:
    - acc with MEM_WAIT >= 2: mem_stall = 1, go to WAIT, cnt <= MEM_WAIT-2.
    - acc with MEM_WAIT == 1: mem_stall = 1, go to DONE.
    - MEM_WAIT == 0: stay in IDLE, mem_stall is never asserted.
  - WAIT: mem_stall = 1. If cnt == 0, go to DONE; otherwise cnt decrements.
  - DONE: mem_stall = 0, go to IDLE unconditionally. This prevents re-triggering on the same instruction.
  - Each access therefore stalls exactly MEM_WAIT cycles. Back-to-back accesses retrigger in the IDLE cycle that follows DONE.
- During mem_stall:
  - pc_hold_o, ifid_hold_o, idex_hold_o, exmem_hold_o, memwb_bubble_o and mem_busy_o are 1.
  - idex_bubble_o and ifid_flush_o are 0. A pending lu/br/flush is re-evaluated once the pipeline unfreezes.
- Simultaneous branch/jump and id_stall: the stall wins, no flush that cycle.
- Reset:
  - While rst_i is high, all outputs are 0.
  - At the clock edge: state <= IDLE and cnt <= 0.
  - Reset mid-WAIT abandons the wait; no stall in the cycle after reset deasserts unless acc is present.

Optional Feature:
HAZARD_PERF_EN: adds three 32-bit outputs, all saturating at 32'hFFFF_FFFF and cleared on reset:
- perf_lu_o: cycles with id_stall asserted and mem_stall deasserted.
- perf_mem_o: mem_stall cycles.
- perf_flush_o: ifid_flush_o cycles.
Without the macro these ports and registers do not exist.

Decomposition:
- Package hazard_pkg:
  - FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - mem_state_t enum {IDLE, WAIT, DONE}.
- One sub-module, mem_wait_fsm (inputs acc, clk_i, rst_i; outputs mem_stall, mem_busy). Forwarding and interlock logic stay in the top.

Test Plan:
1. MEM_WAIT=0; ex_src0=3; mem_rd=3/regwrite and wb_rd=3/regwrite -> fwd_sel[1:0]=2'b10. Drop mem_regwrite -> 2'b01. Set rd=0 -> 2'b00.
2. ex_memread with ex_rd=5, id_rs=5 -> 1 cycle with pc_hold, ifid_hold, idex_bubble = 1. Same with id_rt=5 and id_uses_rt=0 -> no stall.
3. id_branch, id_taken, ex_rd=7/regwrite, id_rs=7 -> stall with flush=0. Next cycle, with the hazard cleared -> ifid_flush_o=1 for 1 cycle.
4. MEM_WAIT=3; mem_memread held -> exactly 3 cycles of exmem_hold=memwb_bubble=1, then a DONE cycle with all 0. A second access right after -> 3 more stall cycles.
5. MEM_WAIT=3; lu and jump asserted during the wait -> no idex_bubble or flush until the wait ends.
6. Assert rst_i in the second WAIT cycle -> outputs 0, state IDLE. With HAZARD_PERF_EN, perf_mem_o reads 0 after reset.
